// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on the command and result sides.
// Single-cycle logic/add/sub, iterative shift-add multiply and restoring divide/remainder.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_div0,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_REM = 3'b111;

  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  state_t               state_r, state_s;
  logic [2*WIDTH-1:0]   acc_r, acc_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [WIDTH-1:0]     a_r, a_s, b_r, b_s;
  logic [2:0]           op_r, op_s;
  logic [WIDTH-1:0]     result_r, result_s;
  logic                 zero_r, zero_s, carry_r, carry_s, div0_r, div0_s;
  logic                 in_ready_r, in_ready_s, out_valid_r, out_valid_s, busy_r, busy_s;
  logic                 fin_s;

  logic [WIDTH:0]       add_s, sub_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_acc_s;
  logic [WIDTH:0]       div_trial_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   div_acc_s;

  // Datapath helpers: single-cycle arithmetic and one multiply/divide iteration
  always_comb begin
    add_s       = {1'b0, a} + {1'b0, b};
    sub_s       = {1'b0, a} - {1'b0, b};
    // Upper half accumulates the partial product; carry shifts into the top bit
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    mul_acc_s   = {mul_sum_s, acc_r[WIDTH-1:1]};
    // Upper half is the partial remainder, lower half shifts dividend out and quotient in
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s    = (div_trial_s >= {1'b0, b_r});
    div_rem_s   = div_ge_s ? WIDTH'(div_trial_s - {1'b0, b_r}) : div_trial_s[WIDTH-1:0];
    div_acc_s   = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    a_s      = a_r;
    b_s      = b_r;
    op_s     = op_r;
    result_s = result_r;
    carry_s  = carry_r;
    div0_s   = div0_r;
    zero_s   = zero_r;
    fin_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s     = a;
          b_s     = b;
          op_s    = op;
          carry_s = 1'b0;
          div0_s  = 1'b0;
          case (op)
            OP_ADD: begin result_s = add_s[WIDTH-1:0]; carry_s = add_s[WIDTH]; fin_s = 1'b1; end
            OP_SUB: begin result_s = sub_s[WIDTH-1:0]; carry_s = sub_s[WIDTH]; fin_s = 1'b1; end
            OP_AND: begin result_s = a & b; fin_s = 1'b1; end
            OP_OR:  begin result_s = a | b; fin_s = 1'b1; end
            OP_XOR: begin result_s = a ^ b; fin_s = 1'b1; end
            OP_MUL: begin
              acc_s   = {ZERO_W, b};
              cnt_s   = CNT_LOAD;
              state_s = CALC;
            end
            OP_DIV, OP_REM: begin
              if (b == ZERO_W) begin
                result_s = (op == OP_DIV) ? ONES_W : a;
                div0_s   = 1'b1;
                fin_s    = 1'b1;
              end else begin
                acc_s   = {ZERO_W, a};
                cnt_s   = CNT_LOAD;
                state_s = CALC;
              end
            end
            default: begin result_s = ZERO_W; fin_s = 1'b1; end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        cnt_s = cnt_r - CNT_ONE;
        acc_s = (op_r == OP_MUL) ? mul_acc_s : div_acc_s;
        if (cnt_r == CNT_ONE) begin
          fin_s = 1'b1;
          case (op_r)
            OP_MUL: begin
              result_s = mul_acc_s[WIDTH-1:0];
              carry_s  = |mul_acc_s[2*WIDTH-1:WIDTH];
            end
            OP_REM:  result_s = div_acc_s[2*WIDTH-1:WIDTH];
            default: result_s = div_acc_s[WIDTH-1:0];
          endcase
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
    if (fin_s) begin
      state_s = DONE;
      zero_s  = (result_s == ZERO_W);
    end else begin
      zero_s = zero_r;
    end
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CW{1'b0}};
      a_r         <= ZERO_W;
      b_r         <= ZERO_W;
      op_r        <= 3'b000;
      result_r    <= ZERO_W;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      div0_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      a_r         <= a_s;
      b_r         <= b_s;
      op_r        <= op_s;
      result_r    <= result_s;
      zero_r      <= zero_s;
      carry_r     <= carry_s;
      div0_r      <= div0_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign result     = result_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;
  assign flag_div0  = div0_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: arithmetic reference model, per-cycle compare
// process, directed corner cases with literal expectations and random traffic.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  logic         flag_zero, flag_carry, flag_div0, busy;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_result;
  logic         exp_carry, exp_zero, exp_div0, exp_pending;
  int           exp_lat;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_div0(flag_div0), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mop);
    longint unsigned x, y, m, full;
    x = ma; y = mb; m = 64'd1 << W;
    exp_carry = 1'b0; exp_div0 = 1'b0; exp_lat = 1;
    case (mop)
      3'd0: begin full = x + y; exp_carry = (full >= m); end
      3'd1: begin full = x + m - y; exp_carry = (x < y); end
      3'd2: begin full = x * y; exp_carry = (full >= m); exp_lat = W + 1; end
      3'd3: if (y == 0) begin full = m - 1; exp_div0 = 1'b1; end
            else begin full = x / y; exp_lat = W + 1; end
      3'd4: full = x & y;
      3'd5: full = x | y;
      3'd6: full = x ^ y;
      default: if (y == 0) begin full = x; exp_div0 = 1'b1; end
               else begin full = x % y; exp_lat = W + 1; end
    endcase
    exp_result = W'(full % m);
    exp_zero   = (exp_result == '0);
  endtask

  // Compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      chk("result_expected", {63'd0, exp_pending}, 64'd1);
      chk("result_flags", {result, flag_carry, flag_zero, flag_div0},
          {exp_result, exp_carry, exp_zero, exp_div0});
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [2:0] top,
                        input int hold, input int lit_r, input int lit_f, input int lit_lat);
    int guard, lat;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("wait_in_ready", {63'd0, in_ready}, 64'd1);
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    out_ready = (hold == 0);
    model(ta, tbv, top);
    @(posedge clk); #1;
    exp_pending = 1'b1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (lit_lat >= 0) chk("latency_lit", lat, lit_lat);
    if (lit_r >= 0) chk("result_lit", {56'd0, result}, lit_r);
    if (lit_f >= 0) chk("flags_lit", {61'd0, flag_carry, flag_zero, flag_div0}, lit_f);
    for (int i = 0; i < hold; i++) begin
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_pending = 1'b0;
    chk("post_hs_idle", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 3'd0; exp_pending = 1'b0;
    exp_result = '0; exp_carry = 1'b0; exp_zero = 1'b0; exp_div0 = 1'b0; exp_lat = 0;
    #12;
    chk("reset_state", {result, flag_zero, flag_carry, flag_div0, out_valid, in_ready, busy},
        {8'd0, 6'b000010});
    @(negedge clk); rst_n = 1'b1;

    run_op(8'd200, 8'd100, 3'd0, 0, 44,  3'b100, 1);
    run_op(8'd5,   8'd7,   3'd1, 0, 254, 3'b100, 1);
    run_op(8'd7,   8'd7,   3'd1, 0, 0,   3'b010, 1);
    run_op(8'd15,  8'd17,  3'd2, 0, 255, 3'b000, 9);
    run_op(8'd16,  8'd16,  3'd2, 0, 0,   3'b110, 9);
    run_op(8'd200, 8'd7,   3'd3, 0, 28,  3'b000, 9);
    run_op(8'd200, 8'd7,   3'd7, 0, 4,   3'b000, 9);
    run_op(8'd5,   8'd9,   3'd3, 0, 0,   3'b010, 9);
    run_op(8'd42,  8'd0,   3'd3, 0, 255, 3'b001, 1);
    run_op(8'd42,  8'd0,   3'd7, 0, 42,  3'b001, 1);
    run_op(8'hF0,  8'h3C,  3'd6, 5, 204, 3'b000, 1);
    run_op(8'd255, 8'd255, 3'd2, 2, 1,   3'b100, 9);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    a = 8'd15; b = 8'd17; op = 3'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {result, out_valid, in_ready, busy}, {8'd0, 3'b010});
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("no_stale_result", seen, 0);

    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) rb = '0;
      run_op(ra, rb, rop, $urandom_range(0, 3), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle ALU with a valid/ready handshake on both the operand side and the result side.
- Widens the 4-bit-operand, single-cycle, free-running ALU to WIDTH-bit operands.
- Adds an iterative shift-add multiplier, a restoring divider/remainder unit, status flags and back-pressure.
- Sits between the pin-level input/output wrapper and any sequencer issuing ALU commands.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).
- CW, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command present on a/b/op
- in_ready  out  1  block can accept a command
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 rem
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- flag_zero  out  1  result == 0
- flag_carry  out  1  add carry-out / sub borrow / mul overflow; 0 otherwise
- flag_div0  out  1  div or rem with b == 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; result=0; all flags=0; out_valid=0; in_ready=1; busy=0; internal counters and accumulators=0.
- Reset mid-calculation aborts the operation; no result is produced.
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid & in_ready. Latch a, b and op.
  - Single-cycle ops (add, sub, and, or, xor) compute at accept and go to DONE.
  - Result is therefore visible 1 cycle after accept.
- div or rem with b==0:
  - Go straight to DONE.
  - div: result = all ones. rem: result = a.
  - flag_div0=1, flag_carry=0.
- mul, and div/rem with b!=0: go to CALC with the counter loaded to WIDTH.
- CALC:
  - in_ready=0. One iteration per cycle.
  - After exactly WIDTH iterations go to DONE.
  - Total latency from accept to out_valid is WIDTH+1 cycles.
- mul (shift-add):
  - Full product is 2*WIDTH bits; result = low WIDTH bits.
  - flag_carry = (high WIDTH bits != 0).
- div/rem (restoring, MSB first):
  - div: result = floor(a/b). rem: result = a mod b.
  - flag_carry=0.
- Arithmetic rules:
  - add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - sub: result = (a-b) mod 2^WIDTH; carry = 1 iff a<b (borrow).
  - Logic ops: flag_carry=0.
- flag_zero is computed from the final result, including the div0 case.
- DONE:
  - out_valid=1.
  - result and flags are held stable until out_valid & out_ready.
  - On that edge go to IDLE and drop out_valid. in_ready is 1 in the next cycle.
  - in_ready=0 throughout DONE; no new command is accepted in the same cycle as the result handshake.
- Result and flags keep their last value while IDLE; they are only meaningful while out_valid=1.
- Inputs a, b and op are don't-care when the block is not accepting. Changes during CALC/DONE must not affect the result.
- Sustained throughput: one single-cycle op every 2 cycles with out_ready held high.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-CALC of a mul.
  - Expect out_valid=0, busy=0, in_ready=1 and result=0 immediately, asynchronously.
  - No stale result after release.
- Add/sub, WIDTH=8:
  - add 200+100: result=44, carry=1, 1-cycle latency.
  - sub 5-7: result=254, carry=1.
  - sub 7-7: result=0, zero=1, carry=0.
- Mul, WIDTH=8:
  - 15*17: result=255, carry=0, out_valid exactly 9 cycles after accept.
  - 16*16: result=0, carry=1, zero=1.
- Div/rem:
  - div 200/7: result=28.
  - rem 200/7: result=4.
  - div 5/9: result=0, zero=1.
  - Each with 9-cycle latency.
- Divide by zero:
  - div 42/0: result=255, div0=1.
  - rem 42/0: result=42, div0=1.
  - Both with 1-cycle latency.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after an xor 0xF0^0x3C.
  - result=0xCC stays stable, in_ready=0, in_valid pulses are ignored.
  - Release: one handshake, then IDLE.
  - Toggle a/b during CALC of a mul: result is unchanged.
